// File: rtl/k_unphase_serial.sv
// Serial un-phaser: undoes a right rotation by k, one left rotation per clock.
// Handshaked in/out; a consume and a new accept may share the same edge.
module k_unphase_serial #(
  parameter int BITSTREAM = 64,
  parameter int K_WIDTH   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [K_WIDTH-1:0]   k,
  input  logic [BITSTREAM-1:0] in_bits,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BITSTREAM-1:0] out_bits,
  output logic                 busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ROT  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [K_WIDTH-1:0]   CNT_ZERO  = K_WIDTH'(0);
  localparam logic [K_WIDTH-1:0]   CNT_ONE   = K_WIDTH'(1);
  localparam logic [BITSTREAM-1:0] WORK_ZERO = BITSTREAM'(0);

  logic [1:0]           state_r;
  logic [1:0]           state_nxt_s;
  logic [BITSTREAM-1:0] work_r;
  logic [BITSTREAM-1:0] work_nxt_s;
  logic [K_WIDTH-1:0]   cnt_r;
  logic [K_WIDTH-1:0]   cnt_nxt_s;
  logic                 accept_s;

  // Handshake decode from the registered state (in DONE, out_ready opens the input)
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready = 1'b1;
      end
      ROT: begin
        busy = 1'b1;
      end
      DONE: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign accept_s = in_valid && in_ready;
  assign out_bits = work_r;

  // Next-state, working register and down-counter update
  always_comb begin
    state_nxt_s = state_r;
    work_nxt_s  = work_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE, DONE: begin
        if (accept_s) begin
          work_nxt_s  = in_bits;
          cnt_nxt_s   = k;
          state_nxt_s = (k != CNT_ZERO) ? ROT : DONE;
        end else if (state_r == DONE && out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ROT: begin
        work_nxt_s = {work_r[BITSTREAM-2:0], work_r[BITSTREAM-1]};
        cnt_nxt_s  = cnt_r - CNT_ONE;
        // Counter hits zero on this edge, so ROT spans exactly k cycles
        if (cnt_r == CNT_ONE) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = ROT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      work_r  <= WORK_ZERO;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      work_r  <= work_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

endmodule

// File: tb/tb_k_unphase_serial.sv
// Bench for k_unphase_serial: a transaction-level model (pending result, due cycle,
// rotated value) is checked every cycle, plus hand-computed literal results.
module tb_k_unphase_serial;

  localparam int W  = 64;
  localparam int KW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [KW-1:0] k;
  logic [W-1:0]  in_bits;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_bits;
  logic          busy;

  k_unphase_serial #(.BITSTREAM(W), .K_WIDTH(KW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .k(k),
    .in_bits(in_bits), .out_valid(out_valid), .out_ready(out_ready),
    .out_bits(out_bits), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input int n);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[(i + n) % W] = v[i];
    return r;
  endfunction

  function automatic logic [W-1:0] rotr(input logic [W-1:0] v, input int n);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[(i + n) % W];
    return r;
  endfunction

  // Transaction model: a result becomes visible k cycles after the accept edge.
  int           cyc       = 0;
  bit           pending   = 1'b0;
  bit           zero_bits = 1'b1;
  int           due_cyc   = 0;
  int           acc_cyc   = 0;
  int           n_acc     = 0;
  logic [W-1:0] exp_bits  = '0;
  bit           chk_en    = 1'b0;

  function automatic bit m_valid();
    return pending && (cyc >= due_cyc);
  endfunction

  initial begin
    forever begin
      bit rdy, cons;
      @(posedge clk);
      cons = m_valid() && out_ready;
      rdy  = !pending || cons;
      cyc++;
      if (rst) begin
        pending   = 1'b0;
        zero_bits = 1'b1;
      end else begin
        if (cons) pending = 1'b0;
        if (in_valid && rdy) begin
          pending   = 1'b1;
          zero_bits = 1'b0;
          exp_bits  = rotl(in_bits, int'(k));
          due_cyc   = cyc + int'(k);
          acc_cyc   = cyc;
          n_acc++;
        end
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge
  initial begin
    forever begin
      bit ev;
      @(negedge clk);
      if (chk_en) begin
        ev = m_valid();
        chk("out_valid", W'(out_valid), W'(ev));
        chk("in_ready", W'(in_ready), W'(!pending || (ev && out_ready)));
        chk("busy", W'(busy), W'(pending));
        if (ev) chk("out_bits", out_bits, exp_bits);
        else if (zero_bits) chk("out_bits_zero", out_bits, '0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [KW-1:0] kk, input logic [W-1:0] b, output int waited);
    int n0 = n_acc;
    waited = 0;
    in_valid = 1'b1;
    k        = kk;
    in_bits  = b;
    while (n_acc == n0 && waited < 40) begin
      step();
      waited++;
    end
    if (n_acc == n0) chk("accept_timeout", W'(n_acc), W'(n0 + 1));
    in_valid = 1'b0;
    k        = ~kk;
    in_bits  = ~b;
  endtask

  task automatic get(output logic [W-1:0] b, output int lat);
    int n = 0;
    b   = '0;
    lat = -1;
    @(negedge clk);
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      chk("result_timeout", W'(out_valid), W'(1));
    end else begin
      b   = out_bits;
      lat = cyc - acc_cyc + 1;
    end
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  logic [W-1:0] got, orig, held;
  logic [W-1:0] words[8];
  int           w8, lat, n_before, seen;
  logic [KW-1:0] kr;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; k = '0; in_bits = '0;
    step();
    chk_en = 1'b1;
    // Reset priority over in_valid on the same edge
    in_valid = 1'b1; in_bits = 64'hDEAD_BEEF_0000_0001; k = 2'd1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_out_bits", out_bits, '0);

    // First accept on the first edge with rst low
    step();
    rst = 1'b0;
    send(2'd1, 64'h0000_0000_0000_0001, w8);
    chk("first_accept_cycles", W'(w8), W'(1));
    get(got, lat);
    chk("k1_bits", got, 64'h0000_0000_0000_0002);
    chk("k1_latency", W'(lat), W'(2));

    send(2'd3, 64'h8000_0000_0000_0001, w8);
    get(got, lat);
    chk("k3_bits", got, 64'h0000_0000_0000_000C);
    chk("k3_latency", W'(lat), W'(4));

    send(2'd0, 64'h8000_0000_0000_0001, w8);
    get(got, lat);
    chk("k0_bits", got, 64'h8000_0000_0000_0001);
    chk("k0_latency", W'(lat), W'(1));

    // Round trip through a right-rotating phaser
    for (int i = 0; i < 200; i++) begin
      orig = {$urandom, $urandom};
      kr   = KW'($urandom_range(0, 3));
      send(kr, rotr(orig, int'(kr)), w8);
      get(got, lat);
      chk("round_trip", got, orig);
      chk("rt_latency", W'(lat), W'(int'(kr) + 1));
    end

    // Stall in DONE while in_valid/in_bits toggle
    send(2'd2, 64'h0123_4567_89AB_CDEF, w8);
    seen = 0;
    while (!out_valid && seen < 20) begin
      step();
      seen++;
    end
    held     = out_bits;
    n_before = n_acc;
    for (int i = 0; i < 10; i++) begin
      step();
      in_valid = ~in_valid;
      in_bits  = {$urandom, $urandom};
      k        = KW'($urandom_range(0, 3));
    end
    @(negedge clk);
    chk("stall_bits", out_bits, held);
    chk("stall_bits_lit", out_bits, 64'h048D_159E_26AF_37BC);
    chk("stall_in_ready", W'(in_ready), W'(0));
    chk("stall_no_accept", W'(n_acc), W'(n_before));
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();

    // Back-to-back k=0 with simultaneous consume and accept
    for (int i = 0; i < 8; i++) words[i] = {$urandom, 32'(i)};
    seen = 0;
    out_ready = 1'b1;
    k = 2'd0;
    for (int i = 0; i <= 8; i++) begin
      in_valid = (i < 8);
      if (i < 8) in_bits = words[i];
      @(negedge clk);
      if (i > 0) begin
        chk("b2b_valid", W'(out_valid), W'(1));
        chk("b2b_bits", out_bits, words[i-1]);
        if (out_valid) seen++;
      end
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("b2b_count", W'(seen), W'(8));
    step();

    // Reset in the middle of a k=3 rotation
    send(2'd3, 64'h0000_0000_0000_00F0, w8);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", W'(in_ready), W'(1));
    chk("abort_busy", W'(busy), W'(0));
    chk("abort_out_bits", out_bits, '0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_valid", W'(out_valid), W'(0));
    end

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d expected=0", 1);
    $fatal(1);
  end

endmodule
